// File: rtl/uart_tx_drain_pkg.sv
// Shared UART transmitter definitions: FSM state encoding and parameter defaults.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned PARITY_EN_DEF    = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

endpackage

// File: rtl/uart_tx_drain_if.sv
// FIFO read side and serial output of the FIFO-draining UART transmitter.
interface uart_tx_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    input  fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, tx_done
  );

  modport slave (
    output fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_drain_baud.sv
// Per-bit timer: counts 0..CLKS_PER_BIT-1 and holds at the terminal value until cleared.
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_clr,
  output logic                            o_tc,
  output logic [$clog2(CLKS_PER_BIT)-1:0] o_count
);
  localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Count up to the terminal value, restart on clear, never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != TERM) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc    = (r_cnt == TERM);
  assign o_count = r_cnt;
endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pulls one byte at a time from an upstream FIFO and
// sends it as 8N1 or 8E1, LSB first.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned PARITY_EN    = PARITY_EN_DEF
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_drain_if.master bus
);
  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] PRE_TERM = CW'(CLKS_PER_BIT - 2);

  logic          r_rst_n;
  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic          r_par;
  logic          w_par_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          r_rd_en;
  logic          r_busy;
  logic          r_tx_done;
  logic          w_tx_done_nxt;
  logic          w_tick;
  logic          w_clr;
  logic [CW-1:0] w_cnt;

  // Reset asserts asynchronously and releases one clock later; the FSM
  // therefore first samples fifo_empty on the second edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_n <= 1'b0;
    else        r_rst_n <= 1'b1;
  end

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst_n   (r_rst_n),
    .i_clr   (w_clr),
    .o_tc    (w_tick),
    .o_count (w_cnt)
  );

  // Next-state, shifter and parity logic; outputs are decoded from the next
  // state so that every output pin comes straight from a flop.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_par_nxt     = r_par;
    unique case (r_state)
      IDLE:  if (!bus.fifo_empty) w_state_nxt = FETCH;
      FETCH: w_state_nxt = LOAD;
      LOAD: begin
        w_shift_nxt   = bus.fifo_data;
        w_par_nxt     = 1'b0;
        w_bit_idx_nxt = '0;
        w_state_nxt   = START;
      end
      START: if (w_tick) w_state_nxt = DATA;
      DATA: begin
        if (w_tick) begin
          w_par_nxt     = r_par ^ r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (w_tick) w_state_nxt = STOP;
      STOP:   if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_clr = (w_state_nxt != r_state) || ((r_state == DATA) && w_tick);

    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_par_nxt;
      default: w_tx_nxt = 1'b1;
    endcase

    // The last STOP cycle follows the one at count CLKS_PER_BIT-2.
    w_tx_done_nxt = (r_state == STOP) && (w_cnt == PRE_TERM);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_par     <= w_par_nxt;
      r_tx      <= w_tx_nxt;
      r_rd_en   <= (w_state_nxt == FETCH);
      r_busy    <= (w_state_nxt != IDLE);
      r_tx_done <= w_tx_done_nxt;
    end
  end

  assign bus.tx         = r_tx;
  assign bus.fifo_rd_en = r_rd_en;
  assign bus.busy       = r_busy;
  assign bus.tx_done    = r_tx_done;
endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: three instances cover 8N1/CPB=4,
// 8E1/CPB=4 and 8N1/CPB=2. A small FIFO model per instance returns the
// queued byte one cycle after each read strobe.
module tb_uart_tx_drain;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_drain_if if0 ();
  uart_tx_drain_if if1 ();
  uart_tx_drain_if if2 ();

  uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  uart_tx_drain #(.CLKS_PER_BIT(2), .PARITY_EN(0)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic [2:0] empty = 3'b111;
  logic [7:0] fdata [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] feed  [3][16];
  int         reads [3] = '{0, 0, 0};
  logic [2:0] seen = 3'b000;

  logic [2:0] w_tx, w_busy, w_rd, w_done;

  assign if0.fifo_empty = empty[0];
  assign if1.fifo_empty = empty[1];
  assign if2.fifo_empty = empty[2];
  assign if0.fifo_data  = fdata[0];
  assign if1.fifo_data  = fdata[1];
  assign if2.fifo_data  = fdata[2];
  assign w_tx   = {if2.tx,         if1.tx,         if0.tx};
  assign w_busy = {if2.busy,       if1.busy,       if0.busy};
  assign w_rd   = {if2.fifo_rd_en, if1.fifo_rd_en, if0.fifo_rd_en};
  assign w_done = {if2.tx_done,    if1.tx_done,    if0.tx_done};

  // FIFO model: data valid for exactly the cycle after a read strobe, zero otherwise.
  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (seen[d]) begin
        fdata[d] = feed[d][reads[d] % 16];
        reads[d] = reads[d] + 1;
      end else begin
        fdata[d] = 8'h00;
      end
      seen[d] = w_rd[d];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int d, input logic [7:0] b0, input logic [7:0] b1);
    feed[d][reads[d] % 16]       = b0;
    feed[d][(reads[d] + 1) % 16] = b1;
  endtask

  task automatic wait_busy(input string nm, input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_busy[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({nm, " busy timeout"}, 0, 1);
  endtask

  // Called at the FETCH negedge; records one frame and checks its shape.
  task automatic check_frame(input string nm, input int d, input logic [10:0] exp,
                             input int nsym, input int cpb, input int exp_len);
    logic [127:0] tr;
    int len, ndone, nrd, done_at;
    tr = '0; len = 0; ndone = 0; nrd = 0; done_at = -1;
    while (w_busy[d] && len < 128) begin
      tr[len] = w_tx[d];
      if (w_done[d]) begin
        ndone++;
        done_at = len;
      end
      if (w_rd[d] && len == 0) nrd++;
      else if (w_rd[d]) nrd += 16;
      len++;
      @(negedge clk);
    end
    chk({nm, " frame length"}, len, exp_len);
    chk({nm, " tx_done count"}, ndone, 1);
    chk({nm, " tx_done position"}, done_at, exp_len - 1);
    chk({nm, " rd_en only in FETCH"}, nrd, 1);
    chk({nm, " tx high in FETCH/LOAD"}, {tr[1], tr[0]}, 2'b11);
    for (int s = 0; s < nsym; s++) begin
      logic v0;
      logic same;
      v0   = tr[2 + s * cpb];
      same = 1'b1;
      for (int c = 1; c < cpb; c++)
        if (tr[2 + s * cpb + c] !== v0) same = 1'b0;
      chk($sformatf("%s symbol %0d {steady,level}", nm, s), {same, v0}, {1'b1, exp[s]});
    end
  endtask

  typedef struct {
    int          d;
    logic [7:0]  b;
    logic [10:0] exp;   // symbol s at bit s: start, data LSB first, [parity], stop
    int          nsym;
    int          cpb;
    int          len;
  } vec_t;

  vec_t vt [6];

  initial begin
    bit   any_rd, any_low, any_busy;
    int   gap;

    $timeformat(-9, 0, " ns", 8);
    vt[0] = '{0, 8'hA5, 11'b01101001010, 10, 4, 42};
    vt[1] = '{1, 8'h07, 11'b11000001110, 11, 4, 46};
    vt[2] = '{1, 8'h03, 11'b10000000110, 11, 4, 46};
    vt[3] = '{2, 8'h00, 11'b01000000000, 10, 2, 22};
    vt[4] = '{0, 8'h3C, 11'b01001111000, 10, 4, 42};
    vt[5] = '{1, 8'h80, 11'b11100000000, 11, 4, 46};

    // Reset values.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset dut%0d {tx,busy,rd,done}", d),
          {w_tx[d], w_busy[d], w_rd[d], w_done[d]}, 4'b1000);
    reset = 1'b1;

    // FIFO empty throughout: nothing moves.
    any_rd = 0; any_low = 0; any_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (w_rd != 3'b000)   any_rd   = 1;
      if (w_tx != 3'b111)   any_low  = 1;
      if (w_busy != 3'b000) any_busy = 1;
    end
    chk("idle no rd_en", any_rd, 0);
    chk("idle tx high", any_low, 0);
    chk("idle not busy", any_busy, 0);

    // Single frames from the vector table.
    for (int i = 0; i < 6; i++) begin
      load(vt[i].d, vt[i].b, 8'h00);
      empty[vt[i].d] = 1'b0;
      wait_busy($sformatf("v%0d", i), vt[i].d);
      empty[vt[i].d] = 1'b1;
      check_frame($sformatf("v%0d", i), vt[i].d, vt[i].exp, vt[i].nsym, vt[i].cpb, vt[i].len);
    end

    // Back-to-back frames with fifo_empty held low.
    load(0, 8'h01, 8'hFF);
    empty[0] = 1'b0;
    wait_busy("b2b", 0);
    check_frame("b2b first", 0, 11'b01000000010, 10, 4, 42);
    gap = 0;
    while (!w_busy[0] && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    chk("b2b idle cycles", gap, 1);
    empty[0] = 1'b1;
    check_frame("b2b second", 0, 11'b01111111110, 10, 4, 42);

    // Reset during data bit 3 abandons the byte.
    load(0, 8'h00, 8'h5A);
    empty[0] = 1'b0;
    wait_busy("rst", 0);
    empty[0] = 1'b1;
    repeat (19) @(negedge clk);
    chk("pre-reset tx in bit3", w_tx[0], 0);
    #2 reset = 1'b0;
    #1;
    chk("async reset {tx,busy,rd,done}", {w_tx[0], w_busy[0], w_rd[0], w_done[0]}, 4'b1000);
    @(negedge clk);
    reset = 1'b1;
    any_rd = 0; any_busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (w_rd[0])   any_rd   = 1;
      if (w_busy[0]) any_busy = 1;
    end
    chk("post-reset no reread", any_rd, 0);
    chk("post-reset not busy", any_busy, 0);

    // Release with data waiting: FETCH on the second rising edge.
    reset = 1'b0;
    @(negedge clk);
    empty[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("release edge1 {busy,rd}", {w_busy[0], w_rd[0]}, 2'b00);
    @(negedge clk);
    chk("release edge2 {busy,rd}", {w_busy[0], w_rd[0]}, 2'b11);
    empty[0] = 1'b1;
    check_frame("after reset", 0, 11'b01010110100, 10, 4, 42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0; 0 = 8N1 frame, 1 = 8E1 frame (even parity bit after data).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, release synchronous to clk.
REQ-005 fifo_empty  input  1  high when the upstream byte FIFO holds no data.
REQ-006 fifo_data  input  8  FIFO read data; valid exactly one cycle after fifo_rd_en high, zero otherwise.
REQ-007 fifo_rd_en  output  1  registered single-cycle read strobe to the FIFO.
REQ-008 tx  output  1  serial line, idle high, LSB first.
REQ-009 busy  output  1  high from FETCH through STOP inclusive.
REQ-010 tx_done  output  1  registered one-cycle pulse marking frame completion.

Function
REQ-011 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-012 IDLE: fifo_empty sampled each cycle; fifo_empty=0 -> FETCH next cycle; fifo_empty ignored in all other states.
REQ-013 FETCH: fifo_rd_en=1 for exactly that one cycle; unconditional -> LOAD.
REQ-014 LOAD: fifo_data captured into 8-bit shift register, parity accumulator cleared; -> START; tx stays 1.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles; -> DATA.
REQ-016 DATA: tx = shift[0]; bit held CLKS_PER_BIT cycles, then shift right, bit index +1; after bit 7 -> PARITY if PARITY_EN=1 else STOP.
REQ-017 PARITY: tx = XOR of the 8 data bits for CLKS_PER_BIT cycles; -> STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 on the last STOP cycle; -> IDLE.
REQ-019 Frame length, FETCH to end of STOP inclusive: 2 + (10+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-020 Back-to-back: with fifo_empty held 0, exactly one IDLE cycle separates STOP end from next FETCH.
REQ-021 Baud counter width = clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, cleared on every state entry; no wrap beyond terminal value.
REQ-022 At most one fifo_rd_en pulse per frame; a byte is never read while busy=1 outside FETCH.
REQ-023 fifo_empty rising after FETCH does not abort the frame.
REQ-024 tx, fifo_rd_en, tx_done SHALL be driven from flops (glitch-free).

Reset
REQ-025 On reset=0: state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, shift register=8'h00, counters=0.
REQ-026 Reset mid-frame abandons the byte (not re-read); tx returns high asynchronously.
REQ-027 First FETCH possible on the second rising edge after reset release with fifo_empty=0.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding constants and default CLKS_PER_BIT / PARITY_EN values.
REQ-029 One sub-module baud_counter SHALL provide the per-bit tick (clear input, terminal-count output); FSM and shifter stay in uart_tx_drain.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-030 fifo_empty=0, fifo_data=8'hA5 in LOAD -> tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_done once; 42-cycle frame.
REQ-031 PARITY_EN=1, byte 8'h07 -> parity bit 1 after bit 7; byte 8'h03 -> parity bit 0; 46-cycle frame.
REQ-032 fifo_empty=0 continuously, bytes 8'h01 then 8'hFF -> two fifo_rd_en pulses, one IDLE cycle between frames.
REQ-033 reset=0 asserted in DATA bit 3 -> tx=1, busy=0 same cycle; after release no read until fifo_empty sampled 0 in IDLE.
REQ-034 fifo_empty=1 throughout -> fifo_rd_en never 1, tx constant 1, busy 0.
REQ-035 CLKS_PER_BIT=2, byte 8'h00 -> start+8 data bits low (18 cycles), stop high 2 cycles, 22-cycle frame.
